regfile_scoreboard_rp: RTL and testbench

Parametrised multi-port register file with registered read ports, write-to-read bypass and a per-register pending (scoreboard) bit that stalls reads of registers awaiting a write. It replaces the fixed 32x32 single-port decoded read mux in the processor's decode stage. Read results are delivered one cycle after acceptance via a ready/valid handshake, so the pipeline can hold an operand fetch until its producer writes back.

---
 rtl/regfile_scoreboard_rp.sv | 109 ++++++++++
 tb/tb_regfile_scoreboard_rp.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_rp.sv
// Multi-port register file with registered read ports, write-to-read bypass
// and a per-register pending (scoreboard) bit. A read of a pending register
// is held off (rd_ready=0) until its producer writes back. The write-back
// cycle itself can satisfy the read through the bypass path.
module regfile_scoreboard_rp #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       ctrl_reset_n,
  input  logic                       ctrl_writeEnable,
  input  logic [ADDR_W-1:0]          ctrl_writeReg,
  input  logic [WIDTH-1:0]           data_writeReg,
  input  logic                       ctrl_reserve,
  input  logic [ADDR_W-1:0]          ctrl_reserveReg,
  input  logic [NUM_RD-1:0]          rd_req,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD-1:0]          rd_ready,
  output logic [NUM_RD-1:0]          rd_valid,
  output logic [NUM_RD*WIDTH-1:0]    rd_data,
  output logic [(1<<ADDR_W)-1:0]     pending
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]                 regs_q [DEPTH];
  logic [DEPTH-1:0]                 pending_q;
  logic [NUM_RD-1:0]                rd_valid_q;
  logic [NUM_RD-1:0][WIDTH-1:0]     rd_data_q;

  logic                             wr_en;
  logic                             rsv_en;
  logic [NUM_RD-1:0][ADDR_W-1:0]    port_addr;
  logic [NUM_RD-1:0]                port_zero;
  logic [NUM_RD-1:0]                port_hit;
  logic [NUM_RD-1:0][WIDTH-1:0]     port_next;

  assign port_addr = rd_addr;

  // Qualify write and reserve strobes: register 0 is hard-wired when ZERO_REG is set.
  always_comb begin
    wr_en  = ctrl_writeEnable && !((ZERO_REG != 0) && (ctrl_writeReg == '0));
    rsv_en = ctrl_reserve     && !((ZERO_REG != 0) && (ctrl_reserveReg == '0));
  end

  // Per-port acceptance and next read value. Acceptance looks only at the
  // pre-edge scoreboard and the write address, never at write data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    port_zero = '0;
    port_hit  = '0;
    port_next = '0;
    rd_ready  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      port_zero[i] = (ZERO_REG != 0) && (port_addr[i] == '0);
      port_hit[i]  = ctrl_writeEnable && (ctrl_writeReg == port_addr[i]);
      rd_ready[i]  = rd_req[i] && (port_zero[i] || !pending_q[port_addr[i]] || port_hit[i]);
      if (port_zero[i]) begin
        port_next[i] = '0;
      end else if (port_hit[i]) begin
        port_next[i] = data_writeReg;
      end else begin
        port_next[i] = regs_q[port_addr[i]];
      end
    end
  end

  // Register array and scoreboard update.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      // NOTE: the array is cleared on reset because reads of never-written registers must return 0; this rules out a RAM macro.
      for (int j = 0; j < DEPTH; j++) begin
        regs_q[j] <= '0;
      end
      pending_q <= '0;
    end else begin
      // NOTE: non-blocking assignments; the reserve below is scheduled later, so it wins over a same-cycle write clear.
      if (wr_en) begin
        regs_q[ctrl_writeReg]    <= data_writeReg;
        pending_q[ctrl_writeReg] <= 1'b0;
      end
      if (rsv_en) begin
        pending_q[ctrl_reserveReg] <= 1'b1;
      end
    end
  end

  // Read pipeline stage: valid follows acceptance, data holds when nothing is accepted.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_ready;
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_ready[i]) begin
          rd_data_q[i] <= port_next[i];
        end
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign pending  = pending_q;

endmodule

// File: tb/tb_regfile_scoreboard_rp.sv
// Testbench for regfile_scoreboard_rp: directed scenarios with fixed expected
// values, then a randomized run against a behavioural model of the register file.
module tb_regfile_scoreboard_rp;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                     clock;
  logic                     ctrl_reset_n;
  logic                     ctrl_writeEnable;
  logic [ADDR_W-1:0]        ctrl_writeReg;
  logic [WIDTH-1:0]         data_writeReg;
  logic                     ctrl_reserve;
  logic [ADDR_W-1:0]        ctrl_reserveReg;
  logic [NUM_RD-1:0]        rd_req;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_ready;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_RD*WIDTH-1:0]  rd_data;
  logic [DEPTH-1:0]         pending;

  int errors = 0;
  int checks = 0;

  regfile_scoreboard_rp #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_reserve     (ctrl_reserve),
    .ctrl_reserveReg  (ctrl_reserveReg),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_ready         (rd_ready),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .pending          (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_in(input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                        input logic res, input logic [4:0] rreg, input logic [1:0] req,
                        input logic [4:0] a0, input logic [4:0] a1);
    ctrl_writeEnable = we;
    ctrl_writeReg    = wreg;
    data_writeReg    = wdata;
    ctrl_reserve     = res;
    ctrl_reserveReg  = rreg;
    rd_req           = req;
    rd_addr          = {a1, a0};
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    ctrl_reset_n = 1'b0;
    idle();
    #2;
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", rd_valid); end
    checks++; if (rd_data !== 64'd0) begin errors++; $display("FAIL reset_data: got %h want 0", rd_data); end
    checks++; if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending); end
    checks++; if (rd_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", rd_ready); end
    #10;
    ctrl_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b01, 5'd5, 5'd0);
    #1;
    checks++; if (rd_ready[0] !== 1'b1) begin errors++; $display("FAIL wr_rd_ready: got %b want 1", rd_ready[0]); end
    tick();
    checks++; if (rd_valid[0] !== 1'b1) begin errors++; $display("FAIL wr_rd_valid: got %b want 1", rd_valid[0]); end
    checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data: got %h want deadbeef", rd_data[31:0]); end
    checks++; if (pending !== 32'd0) begin errors++; $display("FAIL wr_rd_pending: got %h want 0", pending); end
    idle();
  endtask

  task automatic test_bypass();
    set_in(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 2'b10, 5'd0, 5'd7);
    #1;
    checks++; if (rd_ready[1] !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b want 1", rd_ready[1]); end
    tick();
    checks++; if (rd_valid[1] !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b want 1", rd_valid[1]); end
    checks++; if (rd_data[63:32] !== 32'h12345678) begin errors++; $display("FAIL bypass_data: got %h want 12345678", rd_data[63:32]); end
    idle();
  endtask

  task automatic test_stall();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 2'b00, 5'd0, 5'd0);
    tick();
    checks++; if (pending !== 32'h8) begin errors++; $display("FAIL stall_pending_set: got %h want 8", pending); end
    for (int c = 0; c < 4; c++) begin
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b01, 5'd3, 5'd0);
      #1;
      checks++; if (rd_ready[0] !== 1'b0) begin errors++; $display("FAIL stall_ready c%0d: got %b want 0", c, rd_ready[0]); end
      tick();
      checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL stall_valid c%0d: got %b want 0", c, rd_valid[0]); end
      checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_hold c%0d: got %h want deadbeef", c, rd_data[31:0]); end
    end
    set_in(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 2'b01, 5'd3, 5'd0);
    #1;
    checks++; if (rd_ready[0] !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", rd_ready[0]); end
    tick();
    checks++; if (rd_valid[0] !== 1'b1) begin errors++; $display("FAIL stall_release_valid: got %b want 1", rd_valid[0]); end
    checks++; if (rd_data[31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL stall_release_data: got %h want a5a5a5a5", rd_data[31:0]); end
    checks++; if (pending[3] !== 1'b0) begin errors++; $display("FAIL stall_release_pending: got %b want 0", pending[3]); end
    idle();
  endtask

  task automatic test_zero_reg();
    set_in(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 2'b00, 5'd0, 5'd0);
    tick();
    checks++; if (pending !== 32'd0) begin errors++; $display("FAIL zero_pending: got %h want 0", pending); end
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b11, 5'd0, 5'd0);
    #1;
    checks++; if (rd_ready !== 2'b11) begin errors++; $display("FAIL zero_ready: got %b want 11", rd_ready); end
    tick();
    checks++; if (rd_valid !== 2'b11) begin errors++; $display("FAIL zero_valid: got %b want 11", rd_valid); end
    checks++; if (rd_data !== 64'd0) begin errors++; $display("FAIL zero_data: got %h want 0", rd_data); end
    idle();
  endtask

  task automatic test_reserve_write();
    set_in(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 2'b00, 5'd0, 5'd0);
    tick();
    checks++; if (pending !== 32'h200) begin errors++; $display("FAIL rsvwr_pending: got %h want 200", pending); end
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b01, 5'd9, 5'd0);
    #1;
    checks++; if (rd_ready[0] !== 1'b0) begin errors++; $display("FAIL rsvwr_ready: got %b want 0", rd_ready[0]); end
    tick();
    checks++; if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL rsvwr_valid: got %b want 0", rd_valid[0]); end
    idle();
  endtask

  task automatic test_reset_midcycle();
    set_in(1'b1, 5'd2, 32'h0BADF00D, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 2'b10, 5'd0, 5'd2);
    #1;
    checks++; if (rd_ready[1] !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", rd_ready[1]); end
    tick();
    checks++; if (rd_valid[1] !== 1'b1) begin errors++; $display("FAIL rstmid_valid_pre: got %b want 1", rd_valid[1]); end
    checks++; if (rd_data[63:32] !== 32'h0BADF00D) begin errors++; $display("FAIL rstmid_data_pre: got %h want 0badf00d", rd_data[63:32]); end
    checks++; if (pending[4] !== 1'b1) begin errors++; $display("FAIL rstmid_pending_pre: got %b want 1", pending[4]); end
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL rstmid_valid: got %b want 00", rd_valid); end
    checks++; if (rd_data !== 64'd0) begin errors++; $display("FAIL rstmid_data: got %h want 0", rd_data); end
    checks++; if (pending !== 32'd0) begin errors++; $display("FAIL rstmid_pending: got %h want 0", pending); end
    idle();
    #2;
    ctrl_reset_n = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b10, 5'd0, 5'd2);
    #1;
    checks++; if (rd_ready[1] !== 1'b1) begin errors++; $display("FAIL rstmid_post_ready: got %b want 1", rd_ready[1]); end
    tick();
    checks++; if (rd_valid[1] !== 1'b1) begin errors++; $display("FAIL rstmid_post_valid: got %b want 1", rd_valid[1]); end
    checks++; if (rd_data[63:32] !== 32'd0) begin errors++; $display("FAIL rstmid_post_data: got %h want 0", rd_data[63:32]); end
    idle();
  endtask

  // Randomized traffic on a small address window so that reserves, writes and
  // reads collide often. Stalled requesters hold their request stable.
  task automatic test_random();
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pend;
    logic [1:0]  m_valid;
    logic [31:0] m_data [NUM_RD];
    logic [1:0]  hold;
    logic [1:0]  req;
    logic [4:0]  a [NUM_RD];
    logic [1:0]  exp_rdy;
    logic        we, res;
    logic [4:0]  wreg, rreg;
    logic [31:0] wdata;

    #2;
    ctrl_reset_n = 1'b0;
    idle();
    #2;
    ctrl_reset_n = 1'b1;
    for (int r = 0; r < DEPTH; r++) m_mem[r] = 32'd0;
    m_pend  = 32'd0;
    m_valid = 2'b00;
    hold    = 2'b00;
    req     = 2'b00;
    for (int p = 0; p < NUM_RD; p++) begin
      m_data[p] = 32'd0;
      a[p]      = 5'd0;
    end
    tick();

    for (int it = 0; it < 400; it++) begin
      we    = ($urandom % 2) == 0;
      wreg  = 5'($urandom % 8);
      wdata = $urandom;
      res   = ($urandom % 3) == 0;
      rreg  = 5'($urandom % 8);
      for (int p = 0; p < NUM_RD; p++) begin
        if (!hold[p]) begin
          req[p] = ($urandom % 4) != 0;
          a[p]   = 5'($urandom % 8);
        end
      end
      set_in(we, wreg, wdata, res, rreg, req, a[0], a[1]);
      #1;
      // A read is accepted if its register is r0, not awaiting a producer, or being written now.
      for (int p = 0; p < NUM_RD; p++) begin
        exp_rdy[p] = req[p] && (a[p] == 5'd0 || !m_pend[a[p]] || (we && wreg == a[p]));
      end
      checks++; if (rd_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready it%0d: got %b want %b", it, rd_ready, exp_rdy); end
      for (int p = 0; p < NUM_RD; p++) begin
        if (exp_rdy[p]) begin
          if (a[p] == 5'd0)             m_data[p] = 32'd0;
          else if (we && wreg == a[p])  m_data[p] = wdata;
          else                          m_data[p] = m_mem[a[p]];
        end
        hold[p] = req[p] && !exp_rdy[p];
      end
      m_valid = exp_rdy;
      if (we && wreg != 5'd0) begin
        m_mem[wreg]  = wdata;
        m_pend[wreg] = 1'b0;
      end
      if (res && rreg != 5'd0) m_pend[rreg] = 1'b1;
      tick();
      checks++; if (rd_valid !== m_valid) begin errors++; $display("FAIL rand_valid it%0d: got %b want %b", it, rd_valid, m_valid); end
      for (int p = 0; p < NUM_RD; p++) begin
        checks++;
        if (rd_data[p*WIDTH +: WIDTH] !== m_data[p]) begin
          errors++; $display("FAIL rand_data it%0d port%0d: got %h want %h", it, p, rd_data[p*WIDTH +: WIDTH], m_data[p]);
        end
      end
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL rand_pending it%0d: got %h want %h", it, pending, m_pend); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_stall();
    test_zero_reg();
    test_reserve_write();
    test_reset_midcycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
